// File: rtl/ntt_intt_batch_cu.sv
// Batch control unit for the NTT/INTT datapath.
// Sequences up to NUM_POLY polynomials through load, transform and store
// phases, with abort, datapath timeout and a maskable interrupt.
module ntt_intt_batch_cu #(
    parameter int NUM_POLY       = 4,
    parameter int N_COEFF        = 256,
    parameter int COEFF_PER_WORD = 2,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_W      = 16,
    localparam int WORDS = N_COEFF / COEFF_PER_WORD,
    localparam int NPW   = $clog2(NUM_POLY + 1),
    localparam int PW    = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1,
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [NPW-1:0]  npoly_i,
    input  logic            load_valid_i,
    output logic            load_ready_o,
    output logic            store_valid_o,
    input  logic            store_ready_i,
    output logic            dp_start_o,
    input  logic            dp_done_i,
    output logic [OP_W-1:0] op_o,
    output logic [PW-1:0]   poly_idx_o,
    output logic [WW-1:0]   word_idx_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [1:0]      err_code_o,
    input  logic            intr_en_i,
    input  logic            intr_clr_i,
    output logic            intr_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_STORE, S_NEXT, S_DONE
    } state_t;

    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
    // The timeout fires on the cycle the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] TOUT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_NPOLY = 2'd1;
    localparam logic [1:0] ERR_TOUT  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    state_t               state_reg, state_next;
    logic [OP_W-1:0]      op_reg, op_next;
    logic [NPW-1:0]       npoly_reg, npoly_next;
    logic [PW-1:0]        poly_reg, poly_next;
    logic [WW-1:0]        word_reg, word_next;
    logic [TIMEOUT_W-1:0] tcnt_reg, tcnt_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic [1:0]           code_reg, code_next;
    logic                 pend_reg, pend_next;
    logic                 set_pend;
    logic                 bad_npoly;
    logic                 last_poly;

    assign bad_npoly = (npoly_i == '0) || (npoly_i > NPW'(NUM_POLY));
    assign last_poly = ((NPW'(poly_reg) + NPW'(1)) == npoly_reg);

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            npoly_reg <= '0;
            poly_reg  <= '0;
            word_reg  <= '0;
            tcnt_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            npoly_reg <= npoly_next;
            poly_reg  <= poly_next;
            word_reg  <= word_next;
            tcnt_reg  <= tcnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            code_reg  <= code_next;
            pend_reg  <= pend_next;
        end
    end

    // Next-state and counter logic; abort overrides every other transition.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        npoly_next = npoly_reg;
        poly_next  = poly_reg;
        word_next  = word_reg;
        tcnt_next  = tcnt_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        code_next  = code_reg;
        set_pend   = 1'b0;

        if (abort_i && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            poly_next  = '0;
            word_next  = '0;
            tcnt_next  = '0;
            err_next   = 1'b1;
            code_next  = ERR_ABORT;
            set_pend   = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        if (bad_npoly) begin
                            err_next  = 1'b1;
                            code_next = ERR_NPOLY;
                            set_pend  = 1'b1;
                        end else begin
                            op_next    = op_i;
                            npoly_next = npoly_i;
                            done_next  = 1'b0;
                            err_next   = 1'b0;
                            code_next  = ERR_NONE;
                            poly_next  = '0;
                            word_next  = '0;
                            state_next = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_valid_i) begin
                        if (word_reg == LAST_WORD) begin
                            word_next  = '0;
                            state_next = S_RUN;
                        end else begin
                            word_next = word_reg + WW'(1);
                        end
                    end
                end
                S_RUN: begin
                    tcnt_next  = '0;
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (dp_done_i) begin
                        tcnt_next  = '0;
                        state_next = S_STORE;
                    end else if (tcnt_reg == TOUT_LAST) begin
                        tcnt_next  = '0;
                        poly_next  = '0;
                        word_next  = '0;
                        err_next   = 1'b1;
                        code_next  = ERR_TOUT;
                        set_pend   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        tcnt_next = tcnt_reg + TIMEOUT_W'(1);
                    end
                end
                S_STORE: begin
                    if (store_ready_i) begin
                        if (word_reg == LAST_WORD) begin
                            word_next  = '0;
                            state_next = last_poly ? S_DONE : S_NEXT;
                        end else begin
                            word_next = word_reg + WW'(1);
                        end
                    end
                end
                S_NEXT: begin
                    poly_next  = poly_reg + PW'(1);
                    word_next  = '0;
                    state_next = S_LOAD;
                end
                S_DONE: begin
                    done_next  = 1'b1;
                    set_pend   = 1'b1;
                    poly_next  = '0;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end

        // A new interrupt event wins over a simultaneous clear.
        pend_next = set_pend ? 1'b1 : (intr_clr_i ? 1'b0 : pend_reg);
    end

    assign load_ready_o  = (state_reg == S_LOAD);
    assign store_valid_o = (state_reg == S_STORE);
    assign dp_start_o    = (state_reg == S_RUN);
    assign busy_o        = (state_reg != S_IDLE);
    assign op_o          = op_reg;
    assign poly_idx_o    = poly_reg;
    assign word_idx_o    = word_reg;
    assign done_o        = done_reg;
    assign err_o         = err_reg;
    assign err_code_o    = code_reg;
    assign intr_o        = pend_reg & intr_en_i;

endmodule

// File: tb/tb_ntt_intt_batch_cu.sv
// Self-checking bench for ntt_intt_batch_cu: randomized handshakes checked
// against a transfer-counting reference of the batch behaviour.
module tb_ntt_intt_batch_cu;

    localparam int NUM_POLY = 4;
    localparam int N_COEFF  = 256;
    localparam int CPW      = 2;
    localparam int OP_W     = 6;
    localparam int TW       = 4;
    localparam int WORDS    = N_COEFF / CPW;
    localparam int BUDGET   = 6000;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic            abort_i;
    logic [OP_W-1:0] op_i;
    logic [2:0]      npoly_i;
    logic            load_valid_i;
    logic            load_ready_o;
    logic            store_valid_o;
    logic            store_ready_i;
    logic            dp_start_o;
    logic            dp_done_i;
    logic [OP_W-1:0] op_o;
    logic [1:0]      poly_idx_o;
    logic [6:0]      word_idx_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [1:0]      err_code_o;
    logic            intr_en_i;
    logic            intr_clr_i;
    logic            intr_o;

    int checks   = 0;
    int failures = 0;

    ntt_intt_batch_cu #(
        .NUM_POLY(NUM_POLY), .N_COEFF(N_COEFF), .COEFF_PER_WORD(CPW),
        .OP_W(OP_W), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .op_i(op_i), .npoly_i(npoly_i), .load_valid_i(load_valid_i),
        .load_ready_o(load_ready_o), .store_valid_o(store_valid_o),
        .store_ready_i(store_ready_i), .dp_start_o(dp_start_o),
        .dp_done_i(dp_done_i), .op_o(op_o), .poly_idx_o(poly_idx_o),
        .word_idx_o(word_idx_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_code_o(err_code_o), .intr_en_i(intr_en_i),
        .intr_clr_i(intr_clr_i), .intr_o(intr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one batch. Expected word/poly indices at each transfer follow from
    // the running transfer count alone. lat<0 never answers dp_start;
    // abort_poly>=0 aborts on the store of (abort_poly, abort_word).
    task automatic run_batch(input int np, input int op, input int stall, input int lat,
                             input int abort_poly, input int abort_word,
                             output int loads, output int stores, output int starts,
                             output int busy_cycles, output int idx_err,
                             output int wait_len, output bit timed_out);
        int wait_cnt;
        int c_start;
        bit aborted;
        loads = 0; stores = 0; starts = 0; busy_cycles = 0; idx_err = 0;
        wait_len = -1; timed_out = 1'b1; wait_cnt = -1; c_start = -1; aborted = 1'b0;
        @(negedge clk);
        start_i = 1'b1; npoly_i = 3'(np); op_i = OP_W'(op);
        load_valid_i = 1'b0; store_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) @(negedge clk);
            dp_done_i = 1'b0;
            abort_i   = 1'b0;
            if (!busy_o) begin
                start_i   = 1'b0;
                timed_out = 1'b0;
                if (c_start >= 0) wait_len = c - c_start - 1;
                break;
            end
            busy_cycles++;
            // Stray start requests while busy must be ignored.
            start_i = ($urandom_range(9) == 0);
            npoly_i = 3'd0;
            op_i    = OP_W'($urandom);
            if (dp_start_o) begin
                starts++;
                c_start  = c;
                wait_cnt = 0;
            end else if (wait_cnt >= 0) begin
                wait_cnt++;
                if (lat >= 0 && wait_cnt == lat) begin
                    dp_done_i = 1'b1;
                    wait_cnt  = -1;
                end
            end
            load_valid_i = ($urandom_range(99) >= stall);
            if (load_ready_o && load_valid_i) begin
                if (32'(word_idx_o) != loads % WORDS || 32'(poly_idx_o) != loads / WORDS)
                    idx_err++;
                loads++;
            end
            store_ready_i = ($urandom_range(99) >= stall);
            if (store_valid_o && store_ready_i) begin
                if (!aborted && abort_poly >= 0 && stores == abort_poly * WORDS + abort_word) begin
                    abort_i       = 1'b1;
                    store_ready_i = 1'b0;
                    aborted       = 1'b1;
                end else begin
                    if (32'(word_idx_o) != stores % WORDS || 32'(poly_idx_o) != stores / WORDS)
                        idx_err++;
                    stores++;
                end
            end
        end
        start_i = 1'b0; load_valid_i = 1'b0; store_ready_i = 1'b0;
        dp_done_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); intr_clr_i = 1'b1;
        @(negedge clk); intr_clr_i = 1'b0;
    endtask

    int  ld, st, ds, bc, ie, wl, op_a, aw;
    bit  to;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; op_i = '0; npoly_i = '0;
        load_valid_i = 1'b0; store_ready_i = 1'b0; dp_done_i = 1'b0;
        intr_en_i = 1'b1; intr_clr_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_op", op_o, 0);
        check("rst_hs", {load_ready_o, store_valid_o, dp_start_o}, 0);
        check("rst_idx", {poly_idx_o, word_idx_o}, 0);
        check("rst_intr", intr_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single polynomial, no stalls, fixed datapath latency
        run_batch(1, 5, 0, 10, -1, 0, ld, st, ds, bc, ie, wl, to);
        check("t1_timeout", to, 0);
        check("t1_loads", ld, WORDS);
        check("t1_stores", st, WORDS);
        check("t1_dpstart", ds, 1);
        check("t1_latency", bc, 2 * WORDS + 2 + 10);
        check("t1_idx", ie, 0);
        check("t1_done", done_o, 1);
        check("t1_err", err_o, 0);
        check("t1_op", op_o, 5);
        check("t1_intr", intr_o, 1);
        pulse_clr();
        check("t1_intr_clr", intr_o, 0);

        // 2: full batch with random stalls
        op_a = $urandom_range(63);
        run_batch(4, op_a, 30, $urandom_range(1, 12), -1, 0, ld, st, ds, bc, ie, wl, to);
        check("t2_timeout", to, 0);
        check("t2_loads", ld, 4 * WORDS);
        check("t2_stores", st, 4 * WORDS);
        check("t2_dpstart", ds, 4);
        check("t2_idx", ie, 0);
        check("t2_done", done_o, 1);
        check("t2_err", err_o, 0);
        check("t2_op", op_o, op_a);

        // Done arriving on the timeout cycle: done wins
        run_batch(1, 7, 0, 15, -1, 0, ld, st, ds, bc, ie, wl, to);
        check("tb_done_wins_stores", st, WORDS);
        check("tb_done_wins_done", done_o, 1);
        check("tb_done_wins_err", err_o, 0);
        pulse_clr();

        // 3: bad polynomial counts
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); start_i = 1'b1; npoly_i = (k == 0) ? 3'd0 : 3'd5;
            @(negedge clk); start_i = 1'b0;
            check("t3_busy", busy_o, 0);
            @(negedge clk);
            check("t3_busy_late", busy_o, 0);
            check("t3_err", err_o, 1);
            check("t3_code", err_code_o, 1);
            check("t3_intr", intr_o, 1);
            pulse_clr();
        end

        // 4: datapath never finishes
        run_batch(2, 9, 0, -1, -1, 0, ld, st, ds, bc, ie, wl, to);
        check("t4_timeout", to, 0);
        check("t4_wait_len", wl, 15);
        check("t4_err", err_o, 1);
        check("t4_code", err_code_o, 2);
        check("t4_stores", st, 0);
        check("t4_done", done_o, 0);
        check("t4_intr", intr_o, 1);
        pulse_clr();

        // 5: abort during the second polynomial's store
        aw = $urandom_range(WORDS - 1);
        run_batch(3, 11, 20, 5, 1, aw, ld, st, ds, bc, ie, wl, to);
        check("t5_timeout", to, 0);
        check("t5_hs", {load_ready_o, store_valid_o, dp_start_o}, 0);
        check("t5_stores", st, WORDS + aw);
        check("t5_code", err_code_o, 3);
        check("t5_err", err_o, 1);
        check("t5_idx", {poly_idx_o, word_idx_o}, 0);
        check("t5_intr", intr_o, 1);
        pulse_clr();
        op_a = $urandom_range(63);
        run_batch(2, op_a, 25, 3, -1, 0, ld, st, ds, bc, ie, wl, to);
        check("t5_clean_loads", ld, 2 * WORDS);
        check("t5_clean_stores", st, 2 * WORDS);
        check("t5_clean_idx", ie, 0);
        check("t5_clean_done", done_o, 1);
        check("t5_clean_code", err_code_o, 0);
        check("t5_clean_op", op_o, op_a);
        pulse_clr();

        // Abort while idle has no effect
        @(negedge clk); abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        check("idle_abort_err", err_o, 0);
        check("idle_abort_done", done_o, 1);
        check("idle_abort_intr", intr_o, 0);

        // 6: interrupt masking and clear/set collision
        intr_en_i = 1'b0;
        run_batch(1, 2, 0, 4, -1, 0, ld, st, ds, bc, ie, wl, to);
        check("t6_masked", intr_o, 0);
        #1 intr_en_i = 1'b1;
        #1 check("t6_enabled", intr_o, 1);
        pulse_clr();
        check("t6_cleared", intr_o, 0);
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd0; intr_clr_i = 1'b1;
        @(negedge clk); start_i = 1'b0; intr_clr_i = 1'b0;
        check("t6_set_beats_clr", intr_o, 1);
        pulse_clr();
        check("t6_final_clr", intr_o, 0);

        // Reset in the middle of a batch
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd2; op_i = 6'd33; load_valid_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_op", op_o, 0);
        check("mid_rst_word", word_idx_o, 0);
        check("mid_rst_ready", load_ready_o, 0);
        @(negedge clk); load_valid_i = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
